// File: rtl/turf_event_fragmenter_pkg.sv
// Shared types, header field layout and header builder for the event fragmenter.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package turf_frag_pkg;

   // Fragment header field placement (LSB offset and width of each field)
   localparam int HDR_SIG_LSB  = 56;
   localparam int HDR_SIG_W    = 8;
   localparam int HDR_ADDR_LSB = 44;
   localparam int HDR_ADDR_W   = 12;
   localparam int HDR_IDX_LSB  = 34;
   localparam int HDR_IDX_W    = 10;
   localparam int HDR_NFM1_LSB = 24;
   localparam int HDR_NFM1_W   = 10;
   localparam int HDR_RSVD_LSB = 20;
   localparam int HDR_RSVD_W   = 4;
   localparam int HDR_LEN_LSB  = 0;
   localparam int HDR_LEN_W    = 20;

   // A 20-bit byte length rounds up to at most 2^17 words, which needs 18 bits
   localparam int LEN_WORDS_W  = 18;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_HDR,
      S_DATA,
      S_DRAIN,
      S_CHK0
   } frag_state_e;

   // One output beat: last flag, byte enables, payload
   typedef struct packed {
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } frag_beat_t;

   function automatic logic [63:0] frag_header(
      input logic [HDR_SIG_W-1:0]  sig,
      input logic [HDR_ADDR_W-1:0] addr,
      input logic [HDR_IDX_W-1:0]  idx,
      input logic [HDR_NFM1_W-1:0] nfragm1,
      input logic [HDR_LEN_W-1:0]  len
   );
      logic [63:0] h;
      h = '0;
      h[HDR_SIG_LSB  +: HDR_SIG_W]  = sig;
      h[HDR_ADDR_LSB +: HDR_ADDR_W] = addr;
      h[HDR_IDX_LSB  +: HDR_IDX_W]  = idx;
      h[HDR_NFM1_LSB +: HDR_NFM1_W] = nfragm1;
      h[HDR_RSVD_LSB +: HDR_RSVD_W] = '0;
      h[HDR_LEN_LSB  +: HDR_LEN_W]  = len;
      return h;
   endfunction

endpackage

// File: rtl/turf_event_fragmenter_if.sv
// Bundle of the control, data and fragment AXI-stream channels of the fragmenter.
// Latency: n/a (wiring only).
// Backpressure: tvalid/tready on every channel; slave = fragmenter view, master = source/sink view.
interface turf_event_fragmenter_if;

   // Per-event control word: [11:0] address, [31:12] length in bytes
   logic [31:0] s_ctrl_tdata;
   logic        s_ctrl_tvalid;
   logic        s_ctrl_tready;

   // Event data stream
   logic [63:0] s_data_tdata;
   logic [7:0]  s_data_tkeep;
   logic        s_data_tlast;
   logic        s_data_tvalid;
   logic        s_data_tready;

   // Fragment stream towards the UDP transmitter
   logic [63:0] m_frag_tdata;
   logic [7:0]  m_frag_tkeep;
   logic        m_frag_tlast;
   logic        m_frag_tvalid;
   logic        m_frag_tready;

   modport slave (
      input  s_ctrl_tdata, s_ctrl_tvalid,
      output s_ctrl_tready,
      input  s_data_tdata, s_data_tkeep, s_data_tlast, s_data_tvalid,
      output s_data_tready,
      output m_frag_tdata, m_frag_tkeep, m_frag_tlast, m_frag_tvalid,
      input  m_frag_tready
   );

   modport master (
      output s_ctrl_tdata, s_ctrl_tvalid,
      input  s_ctrl_tready,
      output s_data_tdata, s_data_tkeep, s_data_tlast, s_data_tvalid,
      input  s_data_tready,
      input  m_frag_tdata, m_frag_tkeep, m_frag_tlast, m_frag_tvalid,
      output m_frag_tready
   );

endinterface

// File: rtl/turf_event_fragmenter_skid.sv
// Registered output stage plus one-entry skid buffer for a 64b data + 8b keep + last beat.
// Latency: 1 cycle from input accept to out_vld_o.
// Backpressure: in_rdy_o is registered (low only while the skid holds a beat); full 1 beat/cycle.
module axis_skid_64
   import turf_frag_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       in_vld_i,
   output logic       in_rdy_o,
   input  frag_beat_t in_dat_i,
   output logic       out_vld_o,
   input  logic       out_rdy_i,
   output frag_beat_t out_dat_o
);

   logic       out_vld_q;
   frag_beat_t out_dat_q;
   logic       skid_vld_q;
   frag_beat_t skid_dat_q;

   // Output register refills from the skid first, else straight from the input; a beat that
   // arrives while the output is stalled parks in the skid.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
      end else if (!out_vld_q || out_rdy_i) begin
         if (skid_vld_q) begin
            out_vld_q  <= 1'b1;
            out_dat_q  <= skid_dat_q;
            skid_vld_q <= 1'b0;
         end else begin
            out_vld_q <= in_vld_i;
            if (in_vld_i) begin
               out_dat_q <= in_dat_i;
            end
         end
      end else if (in_vld_i && !skid_vld_q) begin
         skid_vld_q <= 1'b1;
         skid_dat_q <= in_dat_i;
      end
   end

   assign in_rdy_o  = !skid_vld_q;
   assign out_vld_o = out_vld_q;
   assign out_dat_o = out_dat_q;

endmodule

// File: rtl/turf_event_fragmenter.sv
// Cuts each event into header-prefixed fragments of up to FRAG_WORDS payload words and checks data length.
// Latency: 1 cycle from input-word accept to m_frag_tvalid (CALC adds one cycle before each event header).
// Backpressure: s_data_tready follows the output skid's space; control accepted only in IDLE.
// Optional statistics counters are built when TURF_FRAG_STATS_EN is defined.
module turf_event_fragmenter
   import turf_frag_pkg::*;
#(
   parameter int         FRAG_WORDS = 128,
   parameter logic [7:0] SIGNATURE  = 8'hE5
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   turf_event_fragmenter_if.slave bus,
   output logic                   err_o,
   output logic                   busy_o
`ifdef TURF_FRAG_STATS_EN
   ,
   output logic [31:0]            event_count_o,
   output logic [31:0]            frag_count_o,
   output logic [15:0]            err_count_o
`endif
);

   localparam int FW_LOG = $clog2(FRAG_WORDS);
   localparam int CNT_W  = FW_LOG + 1;
   localparam logic [CNT_W-1:0] FRAG_FULL = CNT_W'(FRAG_WORDS);

   frag_state_e             state_q;
   logic [HDR_ADDR_W-1:0]   addr_q;
   logic [HDR_LEN_W-1:0]    len_q;
   logic [LEN_WORDS_W-1:0]  rem_q;
   logic [HDR_IDX_W-1:0]    frag_idx_q;
   logic [HDR_NFM1_W-1:0]   nfragm1_q;
   logic [CNT_W-1:0]        frag_cnt_q;
   logic                    err_q;
   logic                    busy_q;
   logic                    ctrl_rdy_q;

   logic                    ctrl_hs;
   logic                    skid_rdy;
   logic                    data_rdy;
   logic                    data_hs;
   logic                    data_end;
   logic                    frag_full;
   logic                    push;
   frag_beat_t              in_beat;
   frag_beat_t              out_beat;
   logic [LEN_WORDS_W-1:0]  rem_next;
   logic [CNT_W-1:0]        cnt_next;

   logic [20:0]             len_round;
   logic [LEN_WORDS_W-1:0]  calc_words;
   logic [LEN_WORDS_W:0]    nfrag_sum;
   logic [LEN_WORDS_W-1:0]  calc_nfrag;
   logic [HDR_NFM1_W-1:0]   calc_nfragm1;

   // Event geometry from the latched length: words rounded up, fragments rounded up (min 1)
   always_comb begin
      len_round    = {1'b0, len_q} + 21'd7;
      calc_words   = len_round[20:3];
      nfrag_sum    = {1'b0, calc_words} + (LEN_WORDS_W+1)'(FRAG_WORDS - 1);
      calc_nfrag   = (calc_words == '0) ? LEN_WORDS_W'(1) : LEN_WORDS_W'(nfrag_sum >> FW_LOG);
      calc_nfragm1 = HDR_NFM1_W'(calc_nfrag - LEN_WORDS_W'(1));
   end

   assign ctrl_hs   = bus.s_ctrl_tvalid && ctrl_rdy_q;
   assign data_rdy  = ((state_q == S_DATA) && skid_rdy) ||
                      (state_q == S_DRAIN) || (state_q == S_CHK0);
   assign data_hs   = bus.s_data_tvalid && data_rdy;
   assign rem_next  = rem_q - LEN_WORDS_W'(1);
   assign cnt_next  = frag_cnt_q + CNT_W'(1);
   assign data_end  = (rem_next == '0);
   assign frag_full = (cnt_next == FRAG_FULL);

   // Beat offered to the output stage: header in HDR, pass-through payload in DATA
   always_comb begin
      push    = 1'b0;
      in_beat = '0;
      case (state_q)
         S_HDR: begin
            push         = skid_rdy;
            in_beat.data = frag_header(SIGNATURE, addr_q, frag_idx_q, nfragm1_q, len_q);
            in_beat.keep = 8'hFF;
            in_beat.last = (rem_q == '0);
         end
         S_DATA: begin
            push         = data_hs;
            in_beat.data = bus.s_data_tdata;
            if (data_end || bus.s_data_tlast) begin
               in_beat.keep = bus.s_data_tkeep;
               in_beat.last = 1'b1;
            end else begin
               in_beat.keep = 8'hFF;
               in_beat.last = frag_full;
            end
         end
         default: begin
            push    = 1'b0;
            in_beat = '0;
         end
      endcase
   end

   // Event sequencing: latch control, size the event, emit headers and payload, check length
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         rem_q      <= '0;
         frag_idx_q <= '0;
         nfragm1_q  <= '0;
         frag_cnt_q <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         ctrl_rdy_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ctrl_hs) begin
                  addr_q     <= bus.s_ctrl_tdata[11:0];
                  len_q      <= bus.s_ctrl_tdata[31:12];
                  ctrl_rdy_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_CALC;
               end else begin
                  ctrl_rdy_q <= 1'b1;
               end
            end
            S_CALC: begin
               rem_q      <= calc_words;
               nfragm1_q  <= calc_nfragm1;
               frag_idx_q <= '0;
               frag_cnt_q <= '0;
               state_q    <= S_HDR;
            end
            S_HDR: begin
               if (skid_rdy) begin
                  frag_cnt_q <= '0;
                  state_q    <= (rem_q == '0) ? S_CHK0 : S_DATA;
               end
            end
            S_DATA: begin
               if (data_hs) begin
                  rem_q      <= rem_next;
                  frag_cnt_q <= cnt_next;
                  if (data_end) begin
                     if (!bus.s_data_tlast) begin
                        err_q   <= 1'b1;
                        state_q <= S_DRAIN;
                     end else begin
                        ctrl_rdy_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                     end
                  end else if (bus.s_data_tlast) begin
                     // Short event: remaining fragments are abandoned
                     err_q      <= 1'b1;
                     ctrl_rdy_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= S_IDLE;
                  end else if (frag_full) begin
                     frag_idx_q <= frag_idx_q + HDR_IDX_W'(1);
                     state_q    <= S_HDR;
                  end
               end
            end
            S_DRAIN: begin
               if (data_hs && bus.s_data_tlast) begin
                  ctrl_rdy_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            S_CHK0: begin
               if (data_hs) begin
                  if (bus.s_data_tlast) begin
                     ctrl_rdy_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_DRAIN;
                  end
               end
            end
            default: begin
               ctrl_rdy_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   axis_skid_64 u_skid (
      .clk_i     (aclk),
      .rst_n_i   (aresetn),
      .in_vld_i  (push),
      .in_rdy_o  (skid_rdy),
      .in_dat_i  (in_beat),
      .out_vld_o (bus.m_frag_tvalid),
      .out_rdy_i (bus.m_frag_tready),
      .out_dat_o (out_beat)
   );

   assign bus.m_frag_tdata  = out_beat.data;
   assign bus.m_frag_tkeep  = out_beat.keep;
   assign bus.m_frag_tlast  = out_beat.last;
   assign bus.s_ctrl_tready = ctrl_rdy_q;
   assign bus.s_data_tready = data_rdy;
   assign err_o             = err_q;
   assign busy_o            = busy_q;

`ifdef TURF_FRAG_STATS_EN
   logic        evt_done;
   logic        mismatch;
   logic        frag_done;
   logic [31:0] event_count_q;
   logic [31:0] frag_count_q;
   logic [15:0] err_count_q;

   // Any tlast consumed in DATA/DRAIN/CHK0 returns the FSM to IDLE
   assign evt_done  = data_hs && bus.s_data_tlast &&
                      ((state_q == S_DATA) || (state_q == S_DRAIN) || (state_q == S_CHK0));
   assign mismatch  = data_hs && (((state_q == S_DATA) && (data_end != bus.s_data_tlast)) ||
                                  ((state_q == S_CHK0) && !bus.s_data_tlast));
   assign frag_done = bus.m_frag_tvalid && bus.m_frag_tready && bus.m_frag_tlast;

   // Event/fragment counters wrap; the mismatch counter saturates
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         event_count_q <= '0;
         frag_count_q  <= '0;
         err_count_q   <= '0;
      end else begin
         if (evt_done) begin
            event_count_q <= event_count_q + 32'd1;
         end
         if (frag_done) begin
            frag_count_q <= frag_count_q + 32'd1;
         end
         if (mismatch && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign event_count_o = event_count_q;
   assign frag_count_o  = frag_count_q;
   assign err_count_o   = err_count_q;
`endif

endmodule
